l2_cache: RTL

- Unified, set-associative, write-back, write-allocate second-level cache between the L1 cache and main memory.
- Serves whole-block reads and whole-block writes from L1 over a level-held request / one-cycle ready handshake.
- On miss: writes a dirty victim back to memory, then fills from memory (reads only).
- Replacement: lowest-numbered invalid way, else the way selected by an external random number.

---
 rtl/l2_cache.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/l2_cache.sv
// Set-associative write-back / write-allocate L2 cache between L1 and main memory.
// Hits complete in one edge; misses optionally write back a dirty victim, then fill.
module l2_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 4096,
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_WAYS   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            l1_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_in,
  input  logic                             l1_read,
  input  logic                             l1_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_out,
  output logic                             l1_ready,
  output logic                             l2_hit,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
  output logic                             mem_read,
  output logic                             mem_write,
  input  logic                             mem_ready,
  input  logic [3:0]                       random_num
);
  localparam int OFFSET_W = $clog2(BLOCK_SIZE);
  localparam int NUM_SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BLK_W    = BLOCK_SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, COOLDOWN} state_t;

  logic [TAG_W-1:0]    tag_mem   [NUM_SETS][NUM_WAYS];
  logic [BLK_W-1:0]    data_mem  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_mem [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_mem [NUM_SETS];

  state_t             state;
  logic [INDEX_W-1:0] idx_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [WAY_W-1:0]   victim_reg;
  logic               write_reg;
  logic [BLK_W-1:0]   data_reg;

  logic [INDEX_W-1:0]  in_idx;
  logic [TAG_W-1:0]    in_tag;
  logic [NUM_WAYS-1:0] hit_vec;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    inv_way;
  logic                any_inv;
  logic [WAY_W-1:0]    victim_way;
  logic                victim_dirty;

  assign in_idx = l1_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign in_tag = l1_addr[ADDR_WIDTH-1 -: TAG_W];

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_cmp
    assign hit_vec[gi] = valid_mem[in_idx][gi] && (tag_mem[in_idx][gi] == in_tag);
  end

  // Descending scan so the lowest-numbered matching / invalid way wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (!valid_mem[in_idx][w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
    victim_way   = any_inv ? inv_way : random_num[WAY_W-1:0];
    victim_dirty = valid_mem[in_idx][victim_way] && dirty_mem[in_idx][victim_way];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      l1_ready     <= 1'b0;
      l2_hit       <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      l1_data_out  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
      end
    end else begin
      l1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (l1_read || l1_write) begin
            idx_reg   <= in_idx;
            tag_reg   <= in_tag;
            write_reg <= l1_write;
            data_reg  <= l1_data_in;
            if (|hit_vec) begin
              if (l1_write) begin
                data_mem[in_idx][hit_way]  <= l1_data_in;
                dirty_mem[in_idx][hit_way] <= 1'b1;
              end else begin
                l1_data_out <= data_mem[in_idx][hit_way];
              end
              l1_ready <= 1'b1;
              l2_hit   <= 1'b1;
              state    <= COOLDOWN;
            end else begin
              victim_reg <= victim_way;
              if (victim_dirty) begin
                mem_write    <= 1'b1;
                mem_addr     <= {tag_mem[in_idx][victim_way], in_idx, {OFFSET_W{1'b0}}};
                mem_data_out <= data_mem[in_idx][victim_way];
                state        <= WRITEBACK;
              end else if (l1_write) begin
                tag_mem[in_idx][victim_way]   <= in_tag;
                data_mem[in_idx][victim_way]  <= l1_data_in;
                valid_mem[in_idx][victim_way] <= 1'b1;
                dirty_mem[in_idx][victim_way] <= 1'b1;
                l1_ready <= 1'b1;
                l2_hit   <= 1'b0;
                state    <= COOLDOWN;
              end else begin
                mem_read <= 1'b1;
                mem_addr <= {in_tag, in_idx, {OFFSET_W{1'b0}}};
                state    <= FILL;
              end
            end
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            dirty_mem[idx_reg][victim_reg] <= 1'b0;
            if (write_reg) begin
              // Later assignment to the same dirty bit wins: the new line is dirty.
              tag_mem[idx_reg][victim_reg]   <= tag_reg;
              data_mem[idx_reg][victim_reg]  <= data_reg;
              valid_mem[idx_reg][victim_reg] <= 1'b1;
              dirty_mem[idx_reg][victim_reg] <= 1'b1;
              l1_ready <= 1'b1;
              l2_hit   <= 1'b0;
              state    <= COOLDOWN;
            end else begin
              mem_read <= 1'b1;
              mem_addr <= {tag_reg, idx_reg, {OFFSET_W{1'b0}}};
              state    <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            tag_mem[idx_reg][victim_reg]   <= tag_reg;
            data_mem[idx_reg][victim_reg]  <= mem_data_in;
            valid_mem[idx_reg][victim_reg] <= 1'b1;
            dirty_mem[idx_reg][victim_reg] <= 1'b0;
            l1_data_out <= mem_data_in;
            l1_ready    <= 1'b1;
            l2_hit      <= 1'b0;
            state       <= COOLDOWN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
